// File: rtl/battle_engine_if.sv
// Signal bundle between the game FSM / sprite logic and battle_engine.
// dbg_state encoding: 0 IDLE, 1 INIT, 2 PLAYER, 3 ENEMY, 4 SWAP, 5 DONE.
interface battle_engine_if;
  // No valid/ready pair here: keycode and is_battle are levels and the engine
  // acts on their edges; end_battle is a one-cycle pulse qualifying result.
  logic            is_battle;
  logic [7:0]      keycode;
  logic [2:0][2:0] my_team;
  logic            end_battle;
  logic            result;
  logic [1:0]      my_cur;
  logic [2:0]      enemy_cur_id;
  logic [7:0]      my_hp;
  logic [7:0]      enemy_hp;
  logic            player_turn;
  logic [2:0]      dbg_state;

  modport master (
    output is_battle, keycode, my_team,
    input  end_battle, result, my_cur, enemy_cur_id, my_hp, enemy_hp,
           player_turn, dbg_state
  );

  modport slave (
    input  is_battle, keycode, my_team,
    output end_battle, result, my_cur, enemy_cur_id, my_hp, enemy_hp,
           player_turn, dbg_state
  );
endinterface

// File: rtl/battle_engine.sv
// Turn-based battle controller: player/enemy attacks, team swaps, win/loss report.
// Optional macro BATTLE_LFSR_EN: pick the enemy from a free-running LFSR instead of a counter.
module battle_engine #(
  parameter logic [7:0] MAX_HP      = 8'd100,
  parameter logic [7:0] DMG_BASE    = 8'd10,
  parameter logic [7:0] ENEMY_DELAY = 8'd60
) (
  input logic            Clk,
  input logic            Reset_n,
  battle_engine_if.slave bus
);
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_A     = 8'h04;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    PLAYER = 3'd2,
    ENEMY  = 3'd3,
    SWAP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_prev_key;
  logic       r_prev_batt;
  logic [7:0] r_dly, w_dly_n;
  logic [7:0] r_my_hp, w_my_hp_n;
  logic [7:0] r_enemy_hp, w_enemy_hp_n;
  logic [1:0] r_my_cur, w_my_cur_n;
  logic       r_result, w_result_n;
  logic [2:0] r_enemy_id, w_enemy_id_n;
  logic [2:0] w_enemy_pick;
  logic [2:0] w_team_id;
  logic [7:0] w_dmg_p, w_dmg_e;
  logic       w_key_evt, w_start, w_abort;
  logic       w_p_lethal, w_e_lethal, w_dly_end;

  assign w_key_evt  = (bus.keycode != r_prev_key) && (bus.keycode != 8'd0);
  assign w_start    = bus.is_battle && !r_prev_batt;
  assign w_abort    = !bus.is_battle && (r_state != IDLE) && (r_state != DONE);
  assign w_team_id  = (r_my_cur == 2'd0) ? bus.my_team[0] :
                      (r_my_cur == 2'd1) ? bus.my_team[1] : bus.my_team[2];
  assign w_dmg_p    = DMG_BASE + {5'd0, w_team_id};
  assign w_dmg_e    = DMG_BASE + {5'd0, r_enemy_id};
  assign w_p_lethal = (r_enemy_hp <= w_dmg_p);
  assign w_e_lethal = (r_my_hp <= w_dmg_e);
  assign w_dly_end  = (r_dly == ENEMY_DELAY - 8'd1);

`ifdef BATTLE_LFSR_EN
  logic [7:0] r_lfsr;

  // x^8+x^6+x^5+x^4+1, shifting towards the MSB every cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_lfsr <= 8'hA5;
    else          r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_enemy_pick = r_lfsr[2:0];
`else
  logic [2:0] r_enemy_ctr;

  // Advances on every INIT, so aborted battles still move to the next enemy
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)              r_enemy_ctr <= 3'd0;
    else if (r_state == INIT)  r_enemy_ctr <= r_enemy_ctr + 3'd1;
  end

  assign w_enemy_pick = r_enemy_ctr;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_prev_key  <= 8'd0;
      r_prev_batt <= 1'b0;
      r_dly       <= 8'd0;
      r_my_hp     <= 8'd0;
      r_enemy_hp  <= 8'd0;
      r_my_cur    <= 2'd0;
      r_result    <= 1'b0;
      r_enemy_id  <= 3'd0;
    end else begin
      r_state     <= w_next;
      r_prev_key  <= bus.keycode;
      r_prev_batt <= bus.is_battle;
      r_dly       <= w_dly_n;
      r_my_hp     <= w_my_hp_n;
      r_enemy_hp  <= w_enemy_hp_n;
      r_my_cur    <= w_my_cur_n;
      r_result    <= w_result_n;
      r_enemy_id  <= w_enemy_id_n;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_dly_n      = 8'd0;
    w_my_hp_n    = r_my_hp;
    w_enemy_hp_n = r_enemy_hp;
    w_my_cur_n   = r_my_cur;
    w_result_n   = r_result;
    w_enemy_id_n = r_enemy_id;

    if (r_state == INIT) begin
      w_my_hp_n    = MAX_HP;
      w_enemy_hp_n = MAX_HP;
      w_my_cur_n   = 2'd0;
      w_result_n   = 1'b0;
      w_enemy_id_n = w_enemy_pick;
    end

    // Abort outranks everything, including a lethal hit in the same cycle
    if (w_abort) begin
      w_next       = IDLE;
      w_my_hp_n    = r_my_hp;
      w_enemy_hp_n = r_enemy_hp;
      w_my_cur_n   = r_my_cur;
      w_result_n   = r_result;
    end else if (w_start) begin
      w_next = INIT;
    end else begin
      case (r_state)
        IDLE: w_next = IDLE;
        INIT: w_next = PLAYER;
        PLAYER: begin
          if (w_key_evt && bus.keycode == KEY_ENTER) begin
            if (w_p_lethal) begin
              w_enemy_hp_n = 8'd0;
              w_result_n   = 1'b1;
              w_next       = DONE;
            end else begin
              w_enemy_hp_n = r_enemy_hp - w_dmg_p;
              w_next       = ENEMY;
            end
          end else if (w_key_evt && bus.keycode == KEY_A) begin
            w_next = ENEMY;
          end
        end
        ENEMY: begin
          if (w_dly_end) begin
            if (w_e_lethal) begin
              w_my_hp_n = 8'd0;
              w_next    = (r_my_cur == 2'd2) ? DONE : SWAP;
            end else begin
              w_my_hp_n = r_my_hp - w_dmg_e;
              w_next    = PLAYER;
            end
          end else begin
            w_dly_n = r_dly + 8'd1;
          end
        end
        SWAP: begin
          w_my_cur_n = r_my_cur + 2'd1;
          w_my_hp_n  = MAX_HP;
          w_next     = PLAYER;
        end
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  assign bus.end_battle   = (r_state == DONE);
  assign bus.player_turn  = (r_state == PLAYER);
  assign bus.result       = r_result;
  assign bus.my_cur       = r_my_cur;
  assign bus.enemy_cur_id = r_enemy_id;
  assign bus.my_hp        = r_my_hp;
  assign bus.enemy_hp     = r_enemy_hp;
  assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_battle_engine.sv
// Self-checking bench for battle_engine against a turn-level battle model.
module tb_battle_engine;
  localparam logic [7:0] MAX_HP      = 8'd100;
  localparam logic [7:0] DMG_BASE    = 8'd10;
  localparam logic [7:0] ENEMY_DELAY = 8'd4;
  localparam logic [7:0] KEY_ENTER   = 8'h28;
  localparam logic [7:0] KEY_A       = 8'h04;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PLAYER   = 3'd2;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  battle_engine_if bus();

  battle_engine #(
    .MAX_HP(MAX_HP), .DMG_BASE(DMG_BASE), .ENEMY_DELAY(ENEMY_DELAY)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int end_pulses = 0;

  // reference model: battle seen as whole turns
  int m_my_hp, m_en_hp, m_cur, m_en_id, m_next_id;
  int team[3];
  logic [7:0] exp_q[$];
  logic [7:0] ign_keys[3] = '{8'h1A, 8'h16, 8'h07};

  always @(negedge Clk) if (Reset_n && bus.end_battle) end_pulses++;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_team(input int s0, input int s1, input int s2);
    team[0] = s0; team[1] = s1; team[2] = s2;
    bus.my_team = {3'(s2), 3'(s1), 3'(s0)};
  endtask

  // one player action followed by the enemy reply, in model terms
  task automatic model_action(input bit attack, output bit ended, output bit won, output int cyc);
    int dmg;
    ended = 0; won = 0; cyc = ENEMY_DELAY;
    if (attack) begin
      dmg = DMG_BASE + team[m_cur];
      if (m_en_hp <= dmg) begin
        m_en_hp = 0; ended = 1; won = 1; cyc = 0;
        return;
      end
      m_en_hp -= dmg;
    end
    dmg = DMG_BASE + m_en_id;
    if (m_my_hp <= dmg) begin
      if (m_cur == 2) begin
        m_my_hp = 0; ended = 1;
      end else begin
        m_cur++; m_my_hp = MAX_HP; cyc = ENEMY_DELAY + 1;
      end
    end else begin
      m_my_hp -= dmg;
    end
  endtask

  // driver: raise is_battle and land in PLAYER; checks the INIT values
  task automatic start_battle();
    bus.keycode = 8'd0;
    bus.is_battle = 1'b0;
    step(); step();
    bus.is_battle = 1'b1;
    step(); step();
    m_my_hp = MAX_HP; m_en_hp = MAX_HP; m_cur = 0;
    m_en_id = m_next_id; m_next_id = (m_next_id + 1) % 8;
    checks++;
    if (bus.player_turn !== 1'b1) begin errors++; $display("FAIL start_turn: got %0d want 1", bus.player_turn); end
    checks++;
    if (bus.my_hp !== MAX_HP || bus.enemy_hp !== MAX_HP) begin
      errors++; $display("FAIL start_hp: got %0d/%0d want 100/100", bus.my_hp, bus.enemy_hp);
    end
    checks++;
    if (bus.enemy_cur_id !== 3'(m_en_id)) begin errors++; $display("FAIL start_enemy: got %0d want %0d", bus.enemy_cur_id, m_en_id); end
    checks++;
    if (bus.my_cur !== 2'd0 || bus.result !== 1'b0) begin
      errors++; $display("FAIL start_cur_result: got %0d/%0d want 0/0", bus.my_cur, bus.result);
    end
  endtask

  // driver: press a key for one cycle and run until PLAYER or end_battle
  task automatic play_turn(input logic [7:0] code, output int cyc, output bit ended,
                           output bit exp_ended, output bit exp_won, output int exp_cyc);
    model_action(code == KEY_ENTER, exp_ended, exp_won, exp_cyc);
    bus.keycode = code;
    step();
    bus.keycode = 8'd0;
    cyc = 0;
    ended = bus.end_battle;
    while (!ended && !bus.player_turn && cyc < 50) begin
      step(); cyc++;
      ended = bus.end_battle;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    bus.is_battle = 1'b0; bus.keycode = 8'd0;
    set_team(7, 3, 0);
    repeat (3) step();
    checks++;
    if ({bus.end_battle, bus.result, bus.my_cur, bus.enemy_cur_id, bus.my_hp, bus.enemy_hp, bus.player_turn} !== '0) begin
      errors++; $display("FAIL reset_outputs: got my_hp=%0d en_hp=%0d turn=%0d want all 0", bus.my_hp, bus.enemy_hp, bus.player_turn);
    end
    @(negedge Clk) Reset_n = 1'b1;
    step();
    checks++;
    if (bus.dbg_state !== ST_IDLE || bus.player_turn !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got state %0d want %0d", bus.dbg_state, ST_IDLE);
    end
    m_next_id = 0;
  endtask

  task automatic test_win();
    int cyc, exp_cyc, p0;
    bit ended, exp_ended, exp_won;
    exp_q = '{8'd83, 8'd66, 8'd49, 8'd32, 8'd15, 8'd0};
    set_team(7, 3, 0);
    start_battle();
    p0 = end_pulses;
    for (int i = 0; i < 6; i++) begin
      play_turn(KEY_ENTER, cyc, ended, exp_ended, exp_won, exp_cyc);
      checks++;
      if (bus.enemy_hp !== exp_q[0] || bus.enemy_hp !== 8'(m_en_hp)) begin
        errors++; $display("FAIL win_enemy_hp[%0d]: got %0d want %0d", i, bus.enemy_hp, exp_q[0]);
      end
      void'(exp_q.pop_front());
      checks++;
      if (ended !== exp_ended || cyc != exp_cyc) begin
        errors++; $display("FAIL win_turn[%0d]: got end=%0d cyc=%0d want end=%0d cyc=%0d", i, ended, cyc, exp_ended, exp_cyc);
      end
      if (ended) break;
    end
    checks++;
    if (bus.result !== 1'b1 || bus.my_hp !== 8'd50) begin
      errors++; $display("FAIL win_final: got result=%0d my_hp=%0d want 1/50", bus.result, bus.my_hp);
    end
    step(); step();
    checks++;
    if (end_pulses - p0 != 1 || bus.dbg_state !== ST_IDLE || bus.result !== 1'b1) begin
      errors++; $display("FAIL win_pulse: got pulses=%0d state=%0d result=%0d want 1/0/1", end_pulses - p0, bus.dbg_state, bus.result);
    end
  endtask

  task automatic test_loss();
    int cyc, exp_cyc, p0, presses;
    bit ended, exp_ended, exp_won;
    start_battle();
    p0 = end_pulses;
    presses = 0;
    for (int i = 0; i < 40; i++) begin
      play_turn(KEY_A, cyc, ended, exp_ended, exp_won, exp_cyc);
      presses++;
      checks++;
      if (bus.my_hp !== 8'(m_my_hp) || bus.my_cur !== 2'(m_cur) || bus.enemy_hp !== MAX_HP) begin
        errors++; $display("FAIL loss_hp[%0d]: got hp=%0d cur=%0d want hp=%0d cur=%0d", i, bus.my_hp, bus.my_cur, m_my_hp, m_cur);
      end
      checks++;
      if (ended !== exp_ended || cyc != exp_cyc) begin
        errors++; $display("FAIL loss_turn[%0d]: got end=%0d cyc=%0d want end=%0d cyc=%0d", i, ended, cyc, exp_ended, exp_cyc);
      end
      if (ended || exp_ended) break;
    end
    checks++;
    if (presses != 30 || bus.result !== 1'b0 || bus.my_cur !== 2'd2 || bus.my_hp !== 8'd0) begin
      errors++; $display("FAIL loss_final: got presses=%0d result=%0d cur=%0d want 30/0/2", presses, bus.result, bus.my_cur);
    end
    step(); step();
    checks++;
    if (end_pulses - p0 != 1) begin errors++; $display("FAIL loss_pulse: got %0d want 1", end_pulses - p0); end
  endtask

  task automatic test_held_key();
    start_battle();
    bus.keycode = KEY_ENTER;
    repeat (20) step();
    bus.keycode = 8'd0;
    step();
    checks++;
    if (bus.enemy_hp !== 8'd83) begin errors++; $display("FAIL held_enemy_hp: got %0d want 83", bus.enemy_hp); end
    checks++;
    if (bus.player_turn !== 1'b1 || bus.my_hp !== 8'(MAX_HP - DMG_BASE - m_en_id)) begin
      errors++; $display("FAIL held_my_hp: got %0d want %0d", bus.my_hp, MAX_HP - DMG_BASE - m_en_id);
    end
    bus.is_battle = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int p0;
    start_battle();
    p0 = end_pulses;
    bus.keycode = KEY_ENTER;
    step();
    bus.keycode = 8'd0;
    step();
    bus.is_battle = 1'b0;
    step();
    checks++;
    if (bus.dbg_state !== ST_IDLE || bus.player_turn !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got state %0d want %0d", bus.dbg_state, ST_IDLE);
    end
    repeat (6) step();
    checks++;
    if (bus.enemy_hp !== 8'd83 || bus.my_hp !== MAX_HP || end_pulses != p0) begin
      errors++; $display("FAIL abort_hold: got en=%0d my=%0d pulses=%0d want 83/100/0", bus.enemy_hp, bus.my_hp, end_pulses - p0);
    end
    start_battle();
  endtask

  task automatic test_async_reset();
    bus.keycode = KEY_A;
    step();
    bus.keycode = 8'd0;
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.end_battle, bus.result, bus.my_cur, bus.enemy_cur_id, bus.my_hp, bus.enemy_hp, bus.player_turn} !== '0
        || bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL async_reset: got my_hp=%0d en_hp=%0d id=%0d state=%0d want all 0",
                         bus.my_hp, bus.enemy_hp, bus.enemy_cur_id, bus.dbg_state);
    end
    bus.is_battle = 1'b0;
    @(negedge Clk) Reset_n = 1'b1;
    step();
    m_next_id = 0;
  endtask

  task automatic test_ignored_keys();
    start_battle();
    foreach (ign_keys[k]) begin
      bus.keycode = ign_keys[k];
      step(); step();
      bus.keycode = 8'd0;
      step();
      checks++;
      if (bus.dbg_state !== ST_PLAYER || bus.my_hp !== MAX_HP || bus.enemy_hp !== MAX_HP) begin
        errors++; $display("FAIL ignored_key_%0h: got state=%0d hp=%0d/%0d want %0d 100/100",
                           ign_keys[k], bus.dbg_state, bus.my_hp, bus.enemy_hp, ST_PLAYER);
      end
    end
    bus.is_battle = 1'b0;
    step();
  endtask

  task automatic test_random_battles();
    int cyc, exp_cyc, p0, r;
    bit ended, exp_ended, exp_won;
    for (int b = 0; b < 4; b++) begin
      set_team($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      start_battle();
      p0 = end_pulses;
      for (int i = 0; i < 200; i++) begin
        repeat ($urandom_range(0, 3)) step();
        r = $urandom_range(0, 9);
        if (r == 9) begin
          bus.keycode = ign_keys[$urandom_range(0, 2)];
          step();
          bus.keycode = 8'd0;
          step();
          checks++;
          if (bus.player_turn !== 1'b1 || bus.enemy_hp !== 8'(m_en_hp)) begin
            errors++; $display("FAIL rand_ignore[%0d]: got turn=%0d en=%0d want 1/%0d", b, bus.player_turn, bus.enemy_hp, m_en_hp);
          end
          continue;
        end
        play_turn((r < 6) ? KEY_ENTER : KEY_A, cyc, ended, exp_ended, exp_won, exp_cyc);
        checks++;
        if (bus.my_hp !== 8'(m_my_hp) || bus.enemy_hp !== 8'(m_en_hp) || bus.my_cur !== 2'(m_cur)) begin
          errors++; $display("FAIL rand_hp[%0d.%0d]: got %0d/%0d cur=%0d want %0d/%0d cur=%0d", b, i,
                             bus.my_hp, bus.enemy_hp, bus.my_cur, m_my_hp, m_en_hp, m_cur);
        end
        checks++;
        if (ended !== exp_ended || cyc != exp_cyc) begin
          errors++; $display("FAIL rand_turn[%0d.%0d]: got end=%0d cyc=%0d want end=%0d cyc=%0d", b, i, ended, cyc, exp_ended, exp_cyc);
        end
        if (ended || exp_ended) break;
      end
      checks++;
      if (bus.result !== exp_won) begin errors++; $display("FAIL rand_result[%0d]: got %0d want %0d", b, bus.result, exp_won); end
      step(); step();
      checks++;
      if (end_pulses - p0 != 1) begin errors++; $display("FAIL rand_pulse[%0d]: got %0d want 1", b, end_pulses - p0); end
    end
  endtask

  initial begin
    bus.is_battle = 1'b0;
    bus.keycode   = 8'd0;
    bus.my_team   = '0;
    test_reset();
    test_win();
    test_loss();
    test_held_key();
    test_abort();
    test_async_reset();
    test_ignored_keys();
    test_random_battles();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
